// File: rtl/blink_seq_pkg.sv
// Shared constants for the LED burst sequencer: FSM state encodings and the
// sizing helper for the per-phase tick counter.
package blink_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_OFF  = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  // Counter must hold 0..max(phase length)-1; never narrower than one bit.
  function automatic int tick_cnt_w(input int on_ticks, input int off_ticks,
                                    input int gap_ticks);
    int m;
    int w;
    m = on_ticks;
    if (off_ticks > m) m = off_ticks;
    if (gap_ticks > m) m = gap_ticks;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/blink_sequencer.sv
// Turns the divider's tick strobe into a burst of `count` LED blinks followed
// by a quiet gap, with start/busy/done handshaking and abort.
module blink_sequencer
  import blink_seq_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1,
  parameter int GAP_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             led
);

  localparam int TW = tick_cnt_w(ON_TICKS, OFF_TICKS, GAP_TICKS);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  state_t             state_q, state_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]   blinks_left_q, blinks_left_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    blinks_left_d = blinks_left_q;
    led_d         = led_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    if (state_q == ST_IDLE) begin
      if (start && (count != '0) && !abort) begin
        state_d       = ST_ON;
        led_d         = 1'b1;
        busy_d        = 1'b1;
        blinks_left_d = count;
        tick_cnt_d    = '0;
      end
    end else if (abort) begin
      // Cancel silently: no done pulse for an aborted burst.
      state_d       = ST_IDLE;
      led_d         = 1'b0;
      busy_d        = 1'b0;
      tick_cnt_d    = '0;
      blinks_left_d = '0;
    end else if (tick) begin
      case (state_q)
        ST_ON: begin
          if (tick_cnt_q == ON_LAST) begin
            led_d         = 1'b0;
            tick_cnt_d    = '0;
            blinks_left_d = blinks_left_q - CNT_W'(1);
            state_d       = (blinks_left_q == CNT_W'(1)) ? ST_GAP : ST_OFF;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_OFF: begin
          if (tick_cnt_q == OFF_LAST) begin
            led_d      = 1'b1;
            tick_cnt_d = '0;
            state_d    = ST_ON;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: begin
          if (tick_cnt_q == GAP_LAST) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      blinks_left_q <= '0;
      led_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      blinks_left_q <= blinks_left_d;
      led_q         <= led_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
